// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop
// bits around an external LSB-first serializer, with a DATA-state watchdog.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TMO_MARGIN = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_load,
    output logic                  ser_en,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  tmo_err
);

    localparam int TMO_LIMIT = DATA_WIDTH + TMO_MARGIN;
    localparam int CW        = $clog2(TMO_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            par_bit;
    logic            par_en_q;
    logic [CW-1:0]   data_cnt;
    logic            accept;
    logic            tmo;

    // Gated by RST so no load strobe escapes while the block is held in reset.
    assign accept = DATA_VALID && !RST && ((state == IDLE) || (state == STOP));
    assign tmo    = (state == DATA) && !ser_done && (data_cnt == CW'(TMO_LIMIT - 1));

    // NOTE: sequential state uses non-blocking assignments and the reset branch
    // is in the sensitivity list, so RST takes effect without waiting for CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parity and its enable are snapshotted at acceptance; later input changes are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
            data_cnt <= '0;
        end else begin
            if (accept) begin
                par_bit  <= (^P_DATA) ^ PAR_TYP;
                par_en_q <= PAR_EN;
            end
            if (state == DATA) begin
                data_cnt <= data_cnt + CW'(1);
            end else begin
                data_cnt <= '0;
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = DATA;
            DATA: begin
                if (ser_done) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end else if (tmo) begin
                    state_nxt = STOP;
                end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // TX_OUT depends only on registered state, ser_data and the parity register.
    always_comb begin
        ser_load = accept;
        ser_en   = 1'b0;
        TX_OUT   = 1'b1;
        Busy     = 1'b1;
        tmo_err  = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
            end
            START: begin
                TX_OUT = 1'b0;
                ser_en = 1'b1;
            end
            DATA: begin
                TX_OUT  = ser_data;
                ser_en  = !ser_done && !tmo;
                tmo_err = tmo;
            end
            PARITY: begin
                TX_OUT = par_bit;
            end
            STOP: begin
                TX_OUT = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: serializer model, frame-level scoreboard,
// directed vector table, back-to-back, timeout and mid-frame reset sequences.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          ser_data;
    logic          ser_done;
    logic          ser_load;
    logic          ser_en;
    logic          TX_OUT;
    logic          Busy;
    logic          tmo_err;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_ctrl #(.DATA_WIDTH(DW), .TMO_MARGIN(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_load   (ser_load),
        .ser_en     (ser_en),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .tmo_err    (tmo_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer model: load resets the shift count; each ser_en exposes the next bit next cycle.
    logic [DW-1:0] sh;
    int            s_cnt;
    logic          withhold;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh    <= '0;
            s_cnt <= 0;
        end else if (ser_load) begin
            sh    <= P_DATA;
            s_cnt <= 0;
        end else if (ser_en && s_cnt < 15) begin
            s_cnt <= s_cnt + 1;
        end
    end

    assign ser_data = (s_cnt >= 1 && s_cnt <= DW) ? sh[3'(s_cnt - 1)] : 1'b0;
    assign ser_done = !withhold && (s_cnt == DW);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: each accepted request appends its full expected line sequence.
    logic sb_en;
    logic q[$];
    int   en_cnt;

    initial begin
        int   sz;
        int   ones;
        logic exp_tx;
        logic exp_load;
        forever begin
            @(negedge CLK);
            if (!sb_en || RST) begin
                q.delete();
                en_cnt = 0;
            end else begin
                sz = q.size();
                check("busy", 32'(Busy), 32'(sz != 0));
                exp_tx = (sz != 0) ? q.pop_front() : 1'b1;
                check("tx_out", 32'(TX_OUT), 32'(exp_tx));
                check("load_en_overlap", 32'(ser_load && ser_en), 32'(0));
                check("tmo_err_idle", 32'(tmo_err), 32'(0));
                exp_load = DATA_VALID && (sz <= 1);
                check("ser_load", 32'(ser_load), 32'(exp_load));
                if (ser_en) en_cnt++;
                if (sz == 1) begin
                    check("ser_en_pulses", 32'(en_cnt), 32'(DW));
                    en_cnt = 0;
                end
                if (exp_load) begin
                    ones = 0;
                    q.push_back(1'b0);
                    for (int i = 0; i < DW; i++) begin
                        q.push_back(P_DATA[i]);
                        if (P_DATA[i]) ones++;
                    end
                    if (PAR_EN) q.push_back(((ones % 2) == 1) ^ PAR_TYP);
                    q.push_back(1'b1);
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (!Busy) seen = 1'b1;
        end
        check(nm, 32'(seen), 32'(1));
    endtask

    // Sends one frame, then scrambles the inputs to prove they were latched.
    task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             output int len, output logic [31:0] bits);
        @(posedge CLK); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0; P_DATA = ~d; PAR_TYP = ~pt; PAR_EN = ~pe;
        len  = 0;
        bits = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (!Busy) break;
            bits[len] = TX_OUT;
            len++;
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          pt;
        int            exp_len;
        logic          exp_par;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          len;
        logic [31:0] bits;
        int          loads;
        int          gap;
        logic        drop;
        logic        tmo_a[16];
        logic        busy_a[16];
        logic        tx_a[16];
        logic        en_a[16];
        int          tmo_cnt;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 11, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 11, 1'b1};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 11, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 11, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 11, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 11, 1'b0};

        // Reset state, with a request pending to prove it is ignored.
        RST = 1'b1; withhold = 1'b0; sb_en = 1'b0;
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_tx", 32'(TX_OUT), 32'(1));
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_load", 32'(ser_load), 32'(0));
        check("rst_en", 32'(ser_en), 32'(0));
        check("rst_tmo", 32'(tmo_err), 32'(0));
        @(posedge CLK); #1;
        RST = 1'b0; DATA_VALID = 1'b0;
        sb_en = 1'b1;
        @(negedge CLK);

        foreach (vecs[i]) begin
            run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, len, bits);
            check($sformatf("vec%0d_len", i), 32'(len), 32'(vecs[i].exp_len));
            check($sformatf("vec%0d_start", i), 32'(bits[0]), 32'(0));
            check($sformatf("vec%0d_data", i), 32'(bits[8:1]), 32'(vecs[i].data));
            check($sformatf("vec%0d_stop", i), 32'(bits[len-1]), 32'(1));
            if (vecs[i].pe) check($sformatf("vec%0d_par", i), 32'(bits[9]), 32'(vecs[i].exp_par));
            if (i == 0) check("a5_line", 32'(bits[9:0]), 32'(10'h34A));
        end

        // Back-to-back frames with DATA_VALID held high.
        @(posedge CLK); #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        loads = 0; gap = 0; drop = 1'b0;
        for (int i = 0; i < 30 && loads < 2; i++) begin
            @(negedge CLK);
            if (loads >= 1 && !Busy) drop = 1'b1;
            if (loads >= 1) gap++;
            if (ser_load) loads++;
            if (loads < 2) begin
                @(posedge CLK); #1;
                if (loads >= 1) P_DATA = 8'hFF;
            end
        end
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        check("b2b_loads", 32'(loads), 32'(2));
        check("b2b_gap", 32'(gap), 32'(10));
        check("b2b_busy_held", 32'(drop), 32'(0));
        wait_idle("b2b_idle");

        // Randomized traffic with inputs changing every cycle.
        for (int c = 0; c < 600; c++) begin
            @(posedge CLK); #1;
            P_DATA     = DW'($urandom);
            PAR_EN     = 1'($urandom_range(0, 1));
            PAR_TYP    = 1'($urandom_range(0, 1));
            DATA_VALID = ($urandom_range(0, 3) == 0);
        end
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        wait_idle("rand_idle");

        // Serializer never reports done: watchdog must end the frame.
        sb_en = 1'b0; withhold = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        tmo_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            tmo_a[i] = tmo_err; busy_a[i] = Busy; tx_a[i] = TX_OUT; en_a[i] = ser_en;
            if (tmo_err) tmo_cnt++;
        end
        check("tmo_pulse_cycle", 32'(tmo_a[10]), 32'(1));
        check("tmo_pulse_count", 32'(tmo_cnt), 32'(1));
        check("tmo_en_forced", 32'(en_a[10]), 32'(0));
        check("tmo_en_before", 32'(en_a[9]), 32'(1));
        check("tmo_stop_tx", 32'(tx_a[11]), 32'(1));
        check("tmo_stop_busy", 32'(busy_a[11]), 32'(1));
        check("tmo_idle_busy", 32'(busy_a[12]), 32'(0));
        withhold = 1'b0;

        // Reset pulsed while bit 4 (a zero) is on the line.
        @(posedge CLK); #1;
        P_DATA = 8'hEF; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        check("pre_rst_bit4", 32'(TX_OUT), 32'(0));
        #2;
        RST = 1'b1; DATA_VALID = 1'b1;
        #1;
        check("rst_mid_tx", 32'(TX_OUT), 32'(1));
        check("rst_mid_busy", 32'(Busy), 32'(0));
        check("rst_mid_en", 32'(ser_en), 32'(0));
        check("rst_mid_load", 32'(ser_load), 32'(0));
        @(negedge CLK);
        check("rst_hold_en", 32'(ser_en), 32'(0));
        check("rst_hold_busy", 32'(Busy), 32'(0));
        @(posedge CLK); #1;
        RST = 1'b0; DATA_VALID = 1'b0;
        sb_en = 1'b1;
        @(negedge CLK);
        run_frame(8'h81, 1'b1, 1'b0, len, bits);
        check("post_rst_len", 32'(len), 32'(11));
        check("post_rst_data", 32'(bits[8:1]), 32'(8'h81));
        check("post_rst_par", 32'(bits[9]), 32'(0));
        check("post_rst_stop", 32'(bits[10]), 32'(1));
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
